// File: rtl/fifo_ctrl_dpram_if.sv
// Push/pop handshake bundle for the dual-port RAM FIFO controller.
// The master side produces words and consumes the head.
// The slave side is the controller itself.
interface fifo_ctrl_dpram_if #(
   parameter int DW = 16
) ();
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/fifo_ctrl_dpram.sv
// FIFO controller around a 2**AW x DW dual-port RAM whose reads are registered.
// Pushes are written straight into the RAM. Reads are prefetched into a
// 2-entry skid buffer, which presents a first-word-fall-through pop port.
// count covers every word held: words in the RAM, one word in flight, and
// the words in the buffer.
module fifo_ctrl_dpram #(
   parameter int AW = 6,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   fifo_ctrl_dpram_if.slave bus,
   output logic          ram_we,
   output logic [AW-1:0] ram_a,
   output logic [DW-1:0] ram_di,
   output logic [AW-1:0] ram_dpra,
   input  logic [DW-1:0] ram_dpo,
   output logic [AW:0]   count
);

   localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);
   localparam logic [AW:0] ONE   = (AW+1)'(1);

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [AW:0]   ram_cnt;
   logic          inflight;
   logic [1:0]    buf_cnt;
   logic [DW-1:0] buf0;
   logic [DW-1:0] buf1;
   logic [1:0]    occ;
   logic          full;
   logic          push;
   logic          pop;
   logic          fetch;
   logic          out_valid_i;

   // The pointers carry a wrap bit, so a plain subtraction yields 0..DEPTH
   // and full can be told apart from empty.
   assign ram_cnt      = wr_ptr - rd_ptr;
   assign full         = (ram_cnt == DEPTH);
   assign bus.in_ready = !full;
   assign push         = bus.in_valid & !full;

   assign ram_we   = push;
   assign ram_a    = wr_ptr[AW-1:0];
   assign ram_di   = bus.in_data;
   assign ram_dpra = rd_ptr[AW-1:0];

   assign out_valid_i   = (buf_cnt != 2'd0);
   assign bus.out_valid = out_valid_i;
   assign bus.out_data  = buf0;
   assign pop           = out_valid_i & bus.out_ready;

   // occ counts the buffered words plus the word in flight, and never exceeds 2.
   // A fetch may issue only if, after this cycle's pop, that total leaves room
   // for the word the fetch will return.
   assign occ   = buf_cnt + {1'b0, inflight};
   assign fetch = (ram_cnt != '0) && (occ < (pop ? 2'd3 : 2'd2));

   assign count = ram_cnt + (AW+1)'(buf_cnt) + (AW+1)'(inflight);

   // Write and read pointers. inflight marks the cycle in which ram_dpo holds a fetched word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + ONE;
         if (fetch)
            rd_ptr <= rd_ptr + ONE;
         inflight <= fetch;
      end
   end

   // Skid buffer: buf0 is the head. A returning word goes to the tail, and a pop shifts buf1 forward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_cnt <= 2'd0;
         buf0    <= '0;
         buf1    <= '0;
      end else begin
         buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
         case ({inflight, pop})
            2'b01: buf0 <= buf1;
            2'b10: begin
               if (buf_cnt == 2'd0)
                  buf0 <= ram_dpo;
               else
                  buf1 <= ram_dpo;
            end
            2'b11: begin
               if (buf_cnt == 2'd1) begin
                  buf0 <= ram_dpo;
               end else begin
                  buf0 <= buf1;
                  buf1 <= ram_dpo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_ctrl_dpram.sv
// Bench for fifo_ctrl_dpram. It includes a read-first dual-port RAM model
// with registered reads. The reference model is a queue of accepted words.
module tb_fifo_ctrl_dpram;

   logic        clk;
   logic        rst_n;
   logic        ram_we;
   logic [5:0]  ram_a;
   logic [15:0] ram_di;
   logic [5:0]  ram_dpra;
   logic [15:0] ram_dpo;
   logic [6:0]  count;

   fifo_ctrl_dpram_if #(.DW(16)) bus ();

   fifo_ctrl_dpram #(.AW(6), .DW(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .ram_we   (ram_we),
      .ram_a    (ram_a),
      .ram_di   (ram_di),
      .ram_dpra (ram_dpra),
      .ram_dpo  (ram_dpo),
      .count    (count)
   );

   logic [15:0] mem [64];

   // RAM model: the write port and the registered read port share one edge, and the read returns the old data.
   always @(posedge clk) begin
      if (ram_we)
         mem[ram_a] <= ram_di;
      ram_dpo <= mem[ram_dpra];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          total;
   int          bad;
   logic [15:0] q [$];
   int unsigned wcnt;
   int          dpra_wraps;
   int          a_wraps;
   logic [5:0]  prev_dpra;
   logic        last_ov;
   logic        last_ir;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle. Drive the inputs, check at the negedge, update the model, then move past the posedge.
   task automatic cycle(input logic iv, input logic [15:0] d, input logic ordy);
      logic push_now;
      logic pop_now;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      @(negedge clk);
      chk("count", 32'(count), q.size());
      if (q.size() < 64)
         chk("in_ready_free", 32'(bus.in_ready), 1);
      if (q.size() >= 66)
         chk("in_ready_full", 32'(bus.in_ready), 0);
      if (bus.out_valid) begin
         chk("ov_nonempty", 32'(q.size() > 0), 1);
         if (q.size() > 0)
            chk("out_data", 32'(bus.out_data), 32'(q[0]));
      end
      chk("ram_we", 32'(ram_we), 32'(iv & bus.in_ready));
      if (ram_we) begin
         chk("ram_a", 32'(ram_a), 32'(wcnt[5:0]));
         chk("ram_di", 32'(ram_di), 32'(d));
         if (ram_a == 6'd63)
            a_wraps++;
      end
      if (prev_dpra == 6'd63 && ram_dpra == 6'd0)
         dpra_wraps++;
      prev_dpra = ram_dpra;
      push_now  = iv & bus.in_ready;
      pop_now   = bus.out_valid & ordy;
      last_ov   = bus.out_valid;
      last_ir   = bus.in_ready;
      if (pop_now && q.size() > 0)
         void'(q.pop_front());
      if (push_now) begin
         q.push_back(d);
         wcnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && q.size() > 0; i++)
         cycle(1'b0, 16'h0, 1'b1);
      chk("drained", q.size(), 0);
   endtask

   initial begin
      int unsigned start;
      total         = 0;
      bad           = 0;
      wcnt          = 0;
      dpra_wraps    = 0;
      a_wraps       = 0;
      prev_dpra     = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 64; i++)
         mem[i] = '0;

      // Reset values
      rst_n = 1'b0;
      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_count", 32'(count), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_a", 32'(ram_a), 0);
      chk("rst_ram_dpra", 32'(ram_dpra), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single word: three-cycle fall-through, then a pop
      cycle(1'b1, 16'h1234, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      chk("fall_c1", 32'(last_ov), 0);
      cycle(1'b0, 16'h0, 1'b0);
      chk("fall_c2", 32'(last_ov), 0);
      cycle(1'b0, 16'h0, 1'b0);
      chk("fall_c3", 32'(last_ov), 1);
      cycle(1'b0, 16'h0, 1'b1);
      chk("pop_valid", 32'(last_ov), 1);
      cycle(1'b0, 16'h0, 1'b0);
      chk("after_pop_valid", 32'(last_ov), 0);

      // Fill to 66 words, check the full boundary, then drain without bubbles
      for (int k = 0; k < 66; k++) begin
         cycle(1'b1, 16'(k), 1'b0);
         chk("fill_ready", 32'(last_ir), 1);
      end
      cycle(1'b1, 16'hFFFF, 1'b0);
      chk("full_ready", 32'(last_ir), 0);
      chk("count66", 32'(count), 66);
      for (int k = 0; k < 66; k++) begin
         cycle(1'b0, 16'h0, 1'b1);
         chk("no_bubble", 32'(last_ov), 1);
      end
      drain();

      // Streaming: after the fill, out_valid stays high and count stays at 3
      for (int i = 0; i < 200; i++) begin
         cycle(1'b1, 16'(16'h0100 + i), 1'b1);
         if (i >= 3) begin
            chk("stream_valid", 32'(last_ov), 1);
            chk("stream_count", 32'(count), 3);
         end
      end
      drain();

      // Random traffic with random backpressure
      start = wcnt;
      for (int i = 0; i < 20000 && (wcnt - start) < 1000; i++)
         cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      chk("rand_words", wcnt - start, 1000);
      drain();

      // Pointer wrap with at most 10 words buffered
      dpra_wraps = 0;
      a_wraps    = 0;
      start      = wcnt;
      for (int i = 0; i < 5000 && (wcnt - start) < 130; i++)
         cycle(1'(q.size() < 10), 16'($urandom), 1'($urandom_range(0, 1)));
      drain();
      chk("dpra_wraps", 32'(dpra_wraps >= 2), 1);
      chk("ram_a_wraps", 32'(a_wraps >= 2), 1);

      // Reset while a fetch is in flight and 5 words are stored
      for (int k = 0; k < 6; k++)
         cycle(1'b1, 16'(16'h0A00 + k), 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1);
      chk("pre_rst_count", 32'(count), 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
      chk("mid_rst_ram_dpra", 32'(ram_dpra), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      wcnt      = 0;
      prev_dpra = '0;
      @(posedge clk);
      #1;
      cycle(1'b1, 16'hBEEF, 1'b0);
      for (int i = 0; i < 10 && !last_ov; i++)
         cycle(1'b0, 16'h0, 1'b0);
      chk("post_rst_valid", 32'(last_ov), 1);
      chk("post_rst_data", 32'(bus.out_data), 32'h0000BEEF);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl_dpram.md
Name: fifo_ctrl_dpram

Overview:
- Synchronous FIFO controller wrapped around the 64x16 dual-port RAM with registered reads on both ports.
- It is the upstream/downstream glue stage for that RAM:
  - Drives the write port (we, a, di) from a valid/ready push interface.
  - Drives the read address dpra.
  - Captures the registered dpo into a 2-entry output skid buffer.
  - Presents a first-word-fall-through valid/ready pop interface.
- The RAM's spo port is unused.

Parameters:
- AW, 6, RAM address width; RAM depth = 2**AW = 64.
- DW, 16, data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  push request.
- in_ready  out  1  controller can accept a push.
- in_data  in  DW  push data.
- out_valid  out  1  out_data holds the FIFO head.
- out_ready  in  1  consumer accepts the head.
- out_data  out  DW  FIFO head word.
- ram_we  out  1  to RAM we.
- ram_a  out  AW  to RAM a (write address).
- ram_di  out  DW  to RAM di.
- ram_dpra  out  AW  to RAM dpra.
- ram_dpo  in  DW  from RAM dpo; valid the cycle after ram_dpra is sampled.
- count  out  AW+1  total words held (RAM + in flight + buffer), range 0..66.

Behaviour:
- State:
  - wr_ptr, rd_ptr: AW+1 bits each, including a wrap bit.
  - inflight flag: 1 bit.
  - Skid buffer: 2 entries, buf_cnt 0..2, FIFO order.
- Reset (rst_n low, asynchronous): clear wr_ptr, rd_ptr, inflight and buf_cnt. Outputs while in reset:
  - out_valid=0, in_ready=1, count=0, ram_we=0, ram_a=0, ram_dpra=0.
  - out_data is don't-care.
- Push path:
  - ram_cnt = wr_ptr - rd_ptr, modulo 2**(AW+1).
  - full = (ram_cnt == 64); in_ready = !full, combinational from registered pointers.
  - push = in_valid & in_ready.
  - ram_we = push; ram_a = wr_ptr[AW-1:0]; ram_di = in_data (all combinational).
  - wr_ptr increments on push and wraps naturally.
- Fetch path:
  - pop = out_valid & out_ready.
  - fetch = (ram_cnt != 0) & (buf_cnt + inflight - pop < 2).
  - ram_dpra = rd_ptr[AW-1:0], driven constantly.
  - On fetch: rd_ptr increments and inflight is set for the next cycle; otherwise inflight clears.
- Capture: when inflight is 1, ram_dpo is written into the skid buffer tail at the clock edge.
- Output: out_valid = (buf_cnt != 0); out_data = buffer head (registered).
  - buf_cnt next = buf_cnt + inflight - pop.
  - Never exceeds 2, guaranteed by the fetch condition.
- Latency:
  - Push at edge N (ram_cnt visible in cycle N+1).
  - Fetch in cycle N+1.
  - dpo valid in cycle N+2.
  - out_valid=1 in cycle N+3 (3-cycle fall-through).
- Throughput: with out_ready held high and a non-empty RAM, one pop per cycle with no bubbles.
- Collision: a slot written in cycle N cannot be fetched before N+1, so no same-address read/write occurs on one edge for newly written data.
  - Writing into a slot whose fetch issues on the same edge is legal: the RAM is read-first, so the old data is returned.
- Simultaneous push and pop when full: in_ready stays 0 until rd_ptr advances. A fetch frees a slot the following cycle.
- count = ram_cnt + inflight + buf_cnt, registered-state derived.
- Reset mid-operation:
  - All stored data is discarded.
  - A ram_dpo returning after reset deasserts is ignored, because inflight was cleared.
- Pointer wrap: after 64 pushes, wr_ptr[AW-1:0] returns to 0 and the wrap bit toggles. Full/empty stay correct across any number of wraps.

Test Plan:
- Reset, then push 0x1234 at edge 0 with out_ready=0 -> out_valid rises in cycle 3 with out_data=0x1234 and count=1; pop with out_ready=1 -> out_valid=0 and count=0 next cycle.
- Push 0..65 (values 0x0000..0x0041) with out_ready=0:
  - Prefetch fills the 2-entry buffer.
  - in_ready drops only after 66 accepted words; count=66.
  - Then pop all with out_ready=1 -> in-order data and one pop per cycle.
- Continuous push and pop (in_valid=out_ready=1) for 200 words -> after the 3-cycle fill, out_valid is high every cycle, data is in order and count stays constant.
- Random out_ready backpressure with in_valid 50% over 1000 words -> scoreboard matches exactly, buf_cnt is never >2, and in_ready is never 1 when ram_cnt=64.
- Wrap test: push/pop 130 words with at most 10 buffered -> ram_a and ram_dpra wrap 63->0 twice with no data corruption.
- Assert rst_n low in the cycle a fetch is in flight with 5 words stored:
  - Outputs clear asynchronously: out_valid=0, count=0.
  - After release, push 0xBEEF -> the first popped word is 0xBEEF.
